// File: rtl/sextium_mem_arbiter.sv
// Sextium memory arbiter: shares one memory port between the core
// and a loader/DMA master; core has priority, loader is starvation-free.
module sextium_mem_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int MEM_LAT     = 1,
  parameter int LD_WAIT_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] core_addr,
  input  logic          core_read,
  input  logic          core_write,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_done,
  output logic          core_hold,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_lock,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int WW = $clog2(LD_WAIT_MAX + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          cdone_q, cdone_d;
  logic          ldone_q, ldone_d;
  logic [DW-1:0] crdata_q, crdata_d;
  logic [DW-1:0] lrdata_q, lrdata_d;
  logic          busy_q;

  logic core_req;
  logic quiet;
  logic wmax;
  logic grant_ld;
  logic grant_core;

  assign core_req = core_read | core_write;
  // The done cycle is dead for arbitration so a master that still
  // holds its request while seeing done is not served twice.
  assign quiet    = ~(cdone_q | ldone_q);
  assign wmax     = (wcnt_q == WW'(LD_WAIT_MAX));
  assign grant_ld = quiet & ld_req
                  & (ld_lock | wmax | ~core_req);
  assign grant_core = quiet & core_req
                    & ~ld_lock & ~grant_ld;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    wcnt_d   = wcnt_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    cdone_d  = 1'b0;
    ldone_d  = 1'b0;
    crdata_d = crdata_q;
    lrdata_d = lrdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ld || grant_core) begin
          owner_d = grant_ld;
          we_d    = grant_ld ? ld_we : core_write;
          addr_d  = grant_ld ? ld_addr : core_addr;
          wdata_d = grant_ld ? ld_wdata : core_wdata;
          rd_d    = ~we_d;
          wr_d    = we_d;
          state_d = ACCESS;
        end
        if (grant_ld) begin
          wcnt_d = '0;
        end else if (grant_core && ld_req && !wmax) begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      ACCESS: begin
        if (we_q) begin
          cdone_d = ~owner_q;
          ldone_d = owner_q;
          state_d = IDLE;
        end else begin
          lat_d   = LW'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          cdone_d = ~owner_q;
          ldone_d = owner_q;
          if (owner_q) lrdata_d = mem_rdata;
          else crdata_d = mem_rdata;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      wcnt_q   <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cdone_q  <= 1'b0;
      ldone_q  <= 1'b0;
      crdata_q <= '0;
      lrdata_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      wcnt_q   <= wcnt_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cdone_q  <= cdone_d;
      ldone_q  <= ldone_d;
      crdata_q <= crdata_d;
      lrdata_q <= lrdata_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign core_hold  = core_req & ~cdone_q;
  assign core_done  = cdone_q;
  assign core_rdata = crdata_q;
  assign ld_done    = ldone_q;
  assign ld_rdata   = lrdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign busy       = busy_q;

endmodule
